// File: rtl/matrix_mult_seq_ctrl.sv
// rtl/matrix_mult_seq_ctrl.sv - sequential 3x3 matrix multiply, one MAC per cycle
// Operands and result move over valid/ready handshakes; an i/j/k index FSM drives a single multiplier.
module matrix_mult_seq_ctrl #(
   parameter int DW    = 4,
   parameter int ACC_W = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [9*DW-1:0]    a_in,
   input  logic [9*DW-1:0]    b_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [9*ACC_W-1:0] result,
   output logic               busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [9*DW-1:0]    a_q, a_d;
   logic [9*DW-1:0]    b_q, b_d;
   logic [1:0]         i_q, i_d;
   logic [1:0]         j_q, j_d;
   logic [1:0]         k_q, k_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [9*ACC_W-1:0] res_q, res_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   logic [3:0]         a_idx, b_idx, c_idx;
   logic [DW-1:0]      a_el, b_el;
   logic [2*DW-1:0]    prod;
   logic [ACC_W-1:0]   mac_sum;

   // Flat row-major element numbers; element e sits at bit offset (8-e)*width.
   assign a_idx = {2'b00, i_q} * 4'd3 + {2'b00, k_q};
   assign b_idx = {2'b00, k_q} * 4'd3 + {2'b00, j_q};
   assign c_idx = {2'b00, i_q} * 4'd3 + {2'b00, j_q};

   always_comb begin
      a_el = '0;
      b_el = '0;
      for (int e = 0; e < 9; e++) begin
         if (a_idx == 4'(e)) a_el = a_q[(8-e)*DW +: DW];
         if (b_idx == 4'(e)) b_el = b_q[(8-e)*DW +: DW];
      end
   end

   assign prod    = {{DW{1'b0}}, a_el} * {{DW{1'b0}}, b_el};
   assign mac_sum = acc_q + ACC_W'(prod);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      acc_d   = acc_q;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a_in;
               b_d     = b_in;
               i_d     = 2'd0;
               j_d     = 2'd0;
               k_d     = 2'd0;
               acc_d   = '0;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            if (k_q != 2'd2) begin
               acc_d = mac_sum;
               k_d   = k_q + 2'd1;
            end else begin
               for (int e = 0; e < 9; e++) begin
                  if (c_idx == 4'(e)) res_d[(8-e)*ACC_W +: ACC_W] = mac_sum;
               end
               acc_d = '0;
               k_d   = 2'd0;
               if (j_q == 2'd2) begin
                  j_d = 2'd0;
                  if (i_q == 2'd2) begin
                     i_d     = 2'd0;
                     state_d = ST_DONE;
                  end else begin
                     i_d = i_q + 2'd1;
                  end
               end else begin
                  j_d = j_q + 2'd1;
               end
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Handshake flags are registered copies of the next-state decode.
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         i_q         <= 2'd0;
         j_q         <= 2'd0;
         k_q         <= 2'd0;
         acc_q       <= '0;
         res_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         i_q         <= i_d;
         j_q         <= j_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         res_q       <= res_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign result    = res_q;

endmodule
